// File: rtl/loss_derivative_child.sv
// MSE loss-gradient front end: ld_data_out = round(2*(H-Y)*inv_N) in Q8.8, two-stage pipeline with H/last alignment.
// Build option: define LOSS_D_SAT_EN to saturate the difference and the scaled result instead of wrapping.
module loss_derivative_child #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid_in,
    input  logic [15:0]       ld_H_in,
    input  logic [15:0]       ld_Y_in,
    input  logic [15:0]       ld_inv_batch_in,
    input  logic [CNT_W-1:0]  ld_batch_len_in,
    input  logic              ld_stall_in,
    output logic              ld_valid_out,
    output logic [15:0]       ld_data_out,
    output logic [15:0]       ld_H_out,
    output logic              ld_last_out
);

`ifdef LOSS_D_SAT_EN
    function automatic logic [15:0] reduce17(input logic signed [16:0] v);
        if (v > 17'sd32767)       return 16'h7FFF;
        else if (v < -17'sd32768) return 16'h8000;
        else                      return v[15:0];
    endfunction

    function automatic logic [15:0] reduce25(input logic signed [24:0] v);
        if (v > 25'sd32767)       return 16'h7FFF;
        else if (v < -25'sd32768) return 16'h8000;
        else                      return v[15:0];
    endfunction
`else
    function automatic logic [15:0] reduce17(input logic signed [16:0] v);
        return v[15:0];
    endfunction

    function automatic logic [15:0] reduce25(input logic signed [24:0] v);
        return v[15:0];
    endfunction
`endif

    logic [CNT_W-1:0]   r_cnt;
    logic               r_s1_valid;
    logic signed [15:0] r_s1_diff;
    logic [15:0]        r_s1_H;
    logic               r_s1_last;

    logic signed [16:0] w_diff_full;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_rnd;
    logic signed [24:0] w_shift;
    logic               w_is_last;
    logic               w_accept;

    assign w_diff_full = $signed({ld_H_in[15], ld_H_in}) - $signed({ld_Y_in[15], ld_Y_in});
    assign w_prod      = r_s1_diff * $signed(ld_inv_batch_in);
    assign w_rnd       = w_prod + 32'sd64;
    // Taking bits [31:7] of the signed sum is the arithmetic >>>7; shift of 7 folds in the factor 2.
    assign w_shift     = w_rnd[31:7];

    // Lengths 0 and 1 both mean every element closes its batch.
    assign w_is_last = (ld_batch_len_in <= CNT_W'(1)) ||
                       (r_cnt == ld_batch_len_in - CNT_W'(1));
    assign w_accept  = ld_valid_in && !ld_stall_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_is_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_diff  <= '0;
            r_s1_H     <= '0;
            r_s1_last  <= 1'b0;
        end else if (!ld_stall_in) begin
            r_s1_valid <= ld_valid_in;
            if (ld_valid_in) begin
                r_s1_diff <= $signed(reduce17(w_diff_full));
                r_s1_H    <= ld_H_in;
                r_s1_last <= w_is_last;
            end else begin
                r_s1_diff <= '0;
                r_s1_H    <= '0;
                r_s1_last <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_valid_out <= 1'b0;
            ld_data_out  <= '0;
            ld_H_out     <= '0;
            ld_last_out  <= 1'b0;
        end else if (!ld_stall_in) begin
            ld_valid_out <= r_s1_valid;
            ld_H_out     <= r_s1_H;
            ld_last_out  <= r_s1_last;
            ld_data_out  <= r_s1_valid ? reduce25(w_shift) : '0;
        end
    end

endmodule

// File: tb/tb_loss_derivative_child.sv
// Scoreboard bench for loss_derivative_child: expectations queued at accept time, checked as outputs emerge.
module tb_loss_derivative_child;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_valid_in = 1'b0;
    logic [15:0] ld_H_in = '0;
    logic [15:0] ld_Y_in = '0;
    logic [15:0] ld_inv_batch_in = 16'h0040;
    logic [7:0]  ld_batch_len_in = 8'd0;
    logic        ld_stall_in = 1'b0;
    logic        ld_valid_out;
    logic [15:0] ld_data_out;
    logic [15:0] ld_H_out;
    logic        ld_last_out;

    loss_derivative_child #(.CNT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .ld_valid_in     (ld_valid_in),
        .ld_H_in         (ld_H_in),
        .ld_Y_in         (ld_Y_in),
        .ld_inv_batch_in (ld_inv_batch_in),
        .ld_batch_len_in (ld_batch_len_in),
        .ld_stall_in     (ld_stall_in),
        .ld_valid_out    (ld_valid_out),
        .ld_data_out     (ld_data_out),
        .ld_H_out        (ld_H_out),
        .ld_last_out     (ld_last_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] h;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tb_cnt = 0;
    logic adv_edge;

    function automatic logic [15:0] model(input logic [15:0] h, input logic [15:0] y,
                                          input logic [15:0] inv);
        int     d;
        longint p;
        longint r;
        d = int'($signed(h)) - int'($signed(y));
`ifdef LOSS_D_SAT_EN
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
`else
        d = int'($signed(d[15:0]));
`endif
        p = longint'(d) * longint'($signed(inv));
        r = (p + 64) >>> 7;
`ifdef LOSS_D_SAT_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    // Output register advances only on unstalled edges outside reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) adv_edge <= 1'b0;
        else      adv_edge <= !ld_stall_in;
    end

    always @(negedge clk) begin
        if (rst && adv_edge && ld_valid_out) begin
            exp_t e;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output data=%h H=%h last=%b required none",
                         ld_data_out, ld_H_out, ld_last_out);
            end else begin
                e = q.pop_front();
                if (ld_data_out !== e.d || ld_H_out !== e.h || ld_last_out !== e.last) begin
                    n_err++;
                    $display("FAIL scoreboard got data=%h H=%h last=%b required data=%h H=%h last=%b",
                             ld_data_out, ld_H_out, ld_last_out, e.d, e.h, e.last);
                end
            end
        end
    end

    task automatic push(input logic [15:0] h, input logic [15:0] y);
        exp_t e;
        int   bl;
        bl = int'(ld_batch_len_in);
        e.d = model(h, y, ld_inv_batch_in);
        e.h = h;
        e.last = (bl <= 1) || (tb_cnt == bl - 1);
        tb_cnt = e.last ? 0 : tb_cnt + 1;
        q.push_back(e);
    endtask

    task automatic send(input logic [15:0] h, input logic [15:0] y);
        ld_H_in = h;
        ld_Y_in = y;
        ld_valid_in = 1'b1;
        push(h, y);
        @(posedge clk);
        #1;
        ld_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout pending=%0d required 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        ld_valid_in = 1'b0;
        ld_stall_in = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        tb_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++;
        if ({ld_valid_out, ld_data_out, ld_H_out, ld_last_out} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_state got v=%b d=%h H=%h l=%b required all 0",
                     ld_valid_out, ld_data_out, ld_H_out, ld_last_out);
        end
    endtask

    task automatic test_basic;
        do_reset();
        ld_batch_len_in = 8'd0;
        ld_inv_batch_in = 16'h0040;
        send(16'h0200, 16'h0100);
        n_vec++;
        if (ld_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early got valid_out=%b required 0", ld_valid_out);
        end
        idle(1);
        n_vec++;
        if (ld_valid_out !== 1'b1 || ld_data_out !== 16'h0080 || ld_H_out !== 16'h0200) begin
            n_err++;
            $display("FAIL basic got v=%b d=%h H=%h required v=1 d=0080 H=0200",
                     ld_valid_out, ld_data_out, ld_H_out);
        end
        idle(1);
        n_vec++;
        if (ld_valid_out !== 1'b0 || ld_data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL bubble_after got v=%b d=%h required v=0 d=0000",
                     ld_valid_out, ld_data_out);
        end
        drain();
    endtask

    task automatic test_arith;
        logic [15:0] req;
        do_reset();
        ld_batch_len_in = 8'd0;
        ld_inv_batch_in = 16'h0040;
        send(16'hFF00, 16'h0100);
        drain();
        ld_inv_batch_in = 16'h0100;
        send(16'h7F00, 16'h8100);
        idle(1);
`ifdef LOSS_D_SAT_EN
        req = 16'h7FFF;
`else
        req = 16'hFC00;
`endif
        n_vec++;
        if (ld_data_out !== req) begin
            n_err++;
            $display("FAIL overflow got d=%h required %h", ld_data_out, req);
        end
        drain();
        ld_inv_batch_in = 16'h0155;
        for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom));
        send(16'h8000, 16'h7FFF);
        send(16'h0003, 16'h0000);
        drain();
    endtask

    task automatic test_batch_last;
        do_reset();
        ld_inv_batch_in = 16'h0080;
        ld_batch_len_in = 8'd3;
        for (int i = 0; i < 7; i++) send(16'(i * 16'h0100), 16'h0080);
        drain();
        ld_batch_len_in = 8'd0;
        for (int i = 0; i < 3; i++) send(16'h0300, 16'(i));
        drain();
        ld_batch_len_in = 8'd1;
        send(16'h0010, 16'h0020);
        send(16'h0011, 16'h0000);
        idle(1);
        send(16'h0012, 16'h0001);
        drain();
    endtask

    task automatic test_stall;
        logic [33:0] snap;
        do_reset();
        ld_inv_batch_in = 16'h0040;
        ld_batch_len_in = 8'd3;
        send(16'h0400, 16'h0100);
        send(16'h0500, 16'h0100);
        ld_H_in = 16'h0600;
        ld_Y_in = 16'h0100;
        ld_valid_in = 1'b1;
        ld_stall_in = 1'b1;
        push(16'h0600, 16'h0100);
        snap = {ld_valid_out, ld_data_out, ld_H_out, ld_last_out};
        for (int i = 0; i < 3; i++) begin
            idle(1);
            n_vec++;
            if ({ld_valid_out, ld_data_out, ld_H_out, ld_last_out} !== snap) begin
                n_err++;
                $display("FAIL stall_frozen cycle=%0d got %h required %h", i,
                         {ld_valid_out, ld_data_out, ld_H_out, ld_last_out}, snap);
            end
        end
        ld_stall_in = 1'b0;
        idle(1);
        ld_valid_in = 1'b0;
        send(16'h0700, 16'h0100);
        send(16'h0800, 16'h0100);
        drain();
    endtask

    task automatic test_reset_midop;
        do_reset();
        ld_inv_batch_in = 16'h0040;
        ld_batch_len_in = 8'd3;
        send(16'h0200, 16'h0100);
        send(16'h0300, 16'h0100);
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({ld_valid_out, ld_data_out, ld_H_out, ld_last_out} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_midop got v=%b d=%h H=%h l=%b required all 0",
                     ld_valid_out, ld_data_out, ld_H_out, ld_last_out);
        end
        q.delete();
        tb_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0900, 16'h0100);
        send(16'h0A00, 16'h0100);
        send(16'h0B00, 16'h0100);
        send(16'h0C00, 16'h0100);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_batch_last();
        test_stall();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule

// File: doc/loss_derivative_child.md
Name: loss_derivative_child

Overview:
- Per-column backprop front end; sits directly upstream of the leaky-ReLU derivative stage and feeds its data, H and valid inputs.
- Computes the MSE loss gradient dL/dH = 2*(H - Y)/N in Q8.8 fixed point.
- Forwards H aligned with each gradient and flags the last element of each batch.

Parameters:
- CNT_W, 8, width of the batch element counter and of ld_batch_len_in.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ld_valid_in  in  1  input element valid.
- ld_H_in  in  16  signed Q8.8 activation H.
- ld_Y_in  in  16  signed Q8.8 target Y.
- ld_inv_batch_in  in  16  signed Q8.8 value of 1/N; quasi-static within a batch.
- ld_batch_len_in  in  CNT_W  elements per batch; quasi-static within a batch.
- ld_stall_in  in  1  freeze the whole pipeline.
- ld_valid_out  out  1  gradient valid.
- ld_data_out  out  16  signed Q8.8 gradient.
- ld_H_out  out  16  H delayed to align with ld_data_out.
- ld_last_out  out  1  qualifies the last element of a batch.

Behaviour:
- Reset (rst=0, async):
  - all outputs and internal registers go to 0.
  - element counter goes to 0.
  - any in-flight data is discarded, including mid-batch.
- Pipeline has two register stages; latency is 2 cycles from ld_valid_in to ld_valid_out when not stalled.
- Stage 1, on each non-stalled cycle:
  - s1_valid <= ld_valid_in.
  - If ld_valid_in=1: s1_diff <= H - Y (17-bit exact result, reduced to 16 bits per width rule), s1_H <= H, s1_last <= counter-is-last.
  - If ld_valid_in=0: s1_diff, s1_H and s1_last are cleared to 0.
- Stage 2, on each non-stalled cycle:
  - ld_valid_out <= s1_valid, ld_H_out <= s1_H, ld_last_out <= s1_last.
  - ld_data_out <= round(s1_diff * ld_inv_batch_in >>> 7).
  - Shifting by 7 instead of 8 folds in the factor 2.
  - If s1_valid=0, ld_data_out is 0.
- Arithmetic/width rules:
  - Product is the exact 32-bit signed s1_diff * inv.
  - Round half-up: add 0x40, then arithmetic shift right by 7.
  - The result is reduced to 16 bits per width rule.
- Width rule: with LOSS_D_SAT_EN, saturate to [0x8000, 0x7FFF]; without it, two's-complement truncate (wrap).
- Counter:
  - Increments on each accepted element (ld_valid_in=1, stall=0).
  - counter-is-last = (count == batch_len-1). On last, the counter returns to 0.
  - batch_len 0 or 1: every element is flagged last and the counter stays 0.
  - Counter does not advance on bubbles or stalls.
- Stall (ld_stall_in=1):
  - every register (stage 1, stage 2, counter) holds its value.
  - ld_valid_in is ignored; upstream must hold the element.
  - outputs stay stable, including a held ld_valid_out=1; the consumer must not double-count while stalled.
- Simultaneous events:
  - stall has priority over valid.
  - reset has priority over everything.
  - a change of ld_inv_batch_in while an element sits in s1 affects that element; software must change it only between batches.
- No state machine beyond the counter; back-to-back valids sustain 1 element/cycle.

Optional Feature:
- Macro LOSS_D_SAT_EN.
- Defined: subtraction and final scaling saturate to 0x7FFF / 0x8000.
- Undefined: both wrap modulo 2^16, for minimum area. Ports and latency are identical in both builds.

Test Plan:
- Basic: rst pulse, then H=0x0200, Y=0x0100, inv=0x0040, valid 1 cycle -> 2 cycles later valid_out=1, data_out=0x0080, H_out=0x0200; one cycle after that, valid_out=0 and data_out=0.
- Negative: H=0xFF00, Y=0x0100, inv=0x0040 -> data_out=0xFF00 (-1.0).
- Overflow: H=0x7F00, Y=0x8100, inv=0x0100 -> data_out=0x7FFF with LOSS_D_SAT_EN; 0xFC00 without it.
- Batch/last: batch_len=3, 7 back-to-back valids -> ld_last_out high on outputs 3 and 6 only. batch_len=0 -> last on every output.
- Stall: stream 4 valids, assert stall for 3 cycles mid-stream -> outputs frozen during stall, no element lost or duplicated, counter and last flags still correct afterwards.
- Reset mid-op: drop rst to 0 asynchronously (between clock edges) with 2 elements in flight -> all outputs 0 immediately. After release, the first new element yields correct data and the last flag counts from 0.
